pc_run_ctrl: RTL and testbench

PC_RUN_CTRL -- requirements
Module: pc_run_ctrl

---
 rtl/pc_run_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pc_run_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_run_ctrl.sv
// Run/halt controller that gates CPU advance on PC limit, breakpoints, step budget and stop/clear requests.
// Optional macro PC_RUN_CTRL_BP_EN builds the NUM_BP breakpoint comparators; undefined leaves bp ports unused.
//
// state | meaning
// IDLE  | after reset or clear; waits for start_i
// RUN   | CPU may advance (run_en_o gated by hit checks)
// HALT  | stopped; halt_cause_o holds the reason until start_i or clr_i

module pc_run_ctrl #(
   parameter int PC_W   = 32,
   parameter int NUM_BP = 4,
   parameter int STEP_W = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic                   stop_i,
   input  logic                   clr_i,
   input  logic [1:0]             mode_i,
   input  logic [STEP_W-1:0]      step_cnt_i,
   input  logic [PC_W-1:0]        limit_i,
   input  logic [PC_W-1:0]        pc_i,
   input  logic [NUM_BP*PC_W-1:0] bp_addr_i,
   input  logic [NUM_BP-1:0]      bp_en_i,
   output logic                   run_en_o,
   output logic                   pc_clr_o,
   output logic [1:0]             state_o,
   output logic [2:0]             halt_cause_o,
   output logic [31:0]            retired_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } state_t;

   localparam logic [2:0] CAUSE_NONE  = 3'd0;
   localparam logic [2:0] CAUSE_LIMIT = 3'd1;
   localparam logic [2:0] CAUSE_BP    = 3'd2;
   localparam logic [2:0] CAUSE_STEP  = 3'd3;
   localparam logic [2:0] CAUSE_BUDGET = 3'd4;
   localparam logic [2:0] CAUSE_STOP  = 3'd5;

   localparam logic [1:0] MODE_STEP    = 2'b01;
   localparam logic [1:0] MODE_COUNTED = 2'b10;

   state_t              r_state;
   logic [2:0]          r_cause;
   logic [31:0]         r_retired;
   logic [STEP_W-1:0]   r_remaining;
   logic                r_bud_en;
   logic                r_bud_step;
   logic                r_bp_mask;
   logic                r_pc_clr;
   logic                r_clr_q;

   logic                w_limit_hit;
   logic                w_bp_hit;
   logic                w_bp_act;
   logic                w_run_en;
   logic                w_bud_last;
   logic                w_unused_limit;

   assign w_limit_hit    = (pc_i[PC_W-1:2] == limit_i[PC_W-3:0]);
   assign w_unused_limit = ^limit_i[PC_W-1:PC_W-2];

`ifdef PC_RUN_CTRL_BP_EN
   logic [NUM_BP-1:0] w_bp_match;

   for (genvar k = 0; k < NUM_BP; k++) begin : g_bp
      assign w_bp_match[k] = bp_en_i[k] && (bp_addr_i[k*PC_W +: PC_W] == pc_i);
   end

   assign w_bp_hit = |w_bp_match;
`else
   logic w_unused_bp;

   assign w_bp_hit    = 1'b0;
   assign w_unused_bp = ^{bp_addr_i, bp_en_i};
`endif

   // The first RUN cycle ignores breakpoints so a resume executes the halting PC.
   assign w_bp_act   = w_bp_hit && !r_bp_mask;
   assign w_run_en   = (r_state == ST_RUN) && !w_limit_hit && !w_bp_act && !stop_i && !clr_i;
   assign w_bud_last = r_bud_en && (r_remaining == STEP_W'(1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_cause     <= CAUSE_NONE;
         r_retired   <= '0;
         r_remaining <= '0;
         r_bud_en    <= 1'b0;
         r_bud_step  <= 1'b0;
         r_bp_mask   <= 1'b1;
         r_pc_clr    <= 1'b0;
         r_clr_q     <= 1'b0;
      end else begin
         r_clr_q  <= clr_i;
         r_pc_clr <= clr_i && !r_clr_q;

         if (w_run_en && (r_retired != 32'hFFFF_FFFF)) begin
            r_retired <= r_retired + 32'd1;
         end

         if (clr_i) begin
            r_state     <= ST_IDLE;
            r_cause     <= CAUSE_NONE;
            r_retired   <= '0;
            r_remaining <= '0;
            r_bud_en    <= 1'b0;
            r_bp_mask   <= 1'b1;
         end else if (stop_i) begin
            if (r_state != ST_HALT) begin
               r_state <= ST_HALT;
               r_cause <= CAUSE_STOP;
            end
         end else if (start_i && (r_state != ST_RUN)) begin
            r_bp_mask <= 1'b1;
            r_cause   <= CAUSE_NONE;
            if (mode_i == MODE_COUNTED) begin
               r_bud_en    <= 1'b1;
               r_bud_step  <= 1'b0;
               r_remaining <= step_cnt_i;
               if (step_cnt_i == '0) begin
                  r_state <= ST_HALT;
                  r_cause <= CAUSE_BUDGET;
               end else begin
                  r_state <= ST_RUN;
               end
            end else if (mode_i == MODE_STEP) begin
               r_bud_en    <= 1'b1;
               r_bud_step  <= 1'b1;
               r_remaining <= STEP_W'(1);
               r_state     <= ST_RUN;
            end else begin
               r_bud_en    <= 1'b0;
               r_bud_step  <= 1'b0;
               r_remaining <= '0;
               r_state     <= ST_RUN;
            end
         end else if (r_state == ST_RUN) begin
            r_bp_mask <= 1'b0;
            if (w_limit_hit) begin
               r_state <= ST_HALT;
               r_cause <= CAUSE_LIMIT;
            end else if (w_bp_act) begin
               r_state <= ST_HALT;
               r_cause <= CAUSE_BP;
            end else if (w_run_en && r_bud_en) begin
               r_remaining <= r_remaining - STEP_W'(1);
               if (w_bud_last) begin
                  r_state <= ST_HALT;
                  r_cause <= r_bud_step ? CAUSE_STEP : CAUSE_BUDGET;
               end
            end
         end
      end
   end

   assign run_en_o     = w_run_en;
   assign pc_clr_o     = r_pc_clr;
   assign state_o      = r_state;
   assign halt_cause_o = r_cause;
   assign retired_o    = r_retired;

endmodule

// File: tb/tb_pc_run_ctrl.sv
// Directed bench for pc_run_ctrl: a cycle-level reference model checked every cycle plus literal checkpoints.
// Define PC_RUN_CTRL_BP_EN for both RTL and bench to exercise breakpoints.

module tb_pc_run_ctrl;

   localparam int PC_W   = 32;
   localparam int NUM_BP = 4;
   localparam int STEP_W = 16;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic                   start_i = 1'b0;
   logic                   stop_i = 1'b0;
   logic                   clr_i = 1'b0;
   logic [1:0]             mode_i = 2'b00;
   logic [STEP_W-1:0]      step_cnt_i = '0;
   logic [PC_W-1:0]        limit_i = 32'd1000;
   logic [PC_W-1:0]        pc_i = '0;
   logic [NUM_BP*PC_W-1:0] bp_addr_i = '0;
   logic [NUM_BP-1:0]      bp_en_i = '0;
   logic                   run_en_o;
   logic                   pc_clr_o;
   logic [1:0]             state_o;
   logic [2:0]             halt_cause_o;
   logic [31:0]            retired_o;

   int n_vec = 0;
   int n_err = 0;
   bit mon_on = 1'b0;

   pc_run_ctrl #(.PC_W(PC_W), .NUM_BP(NUM_BP), .STEP_W(STEP_W)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start_i), .stop_i(stop_i), .clr_i(clr_i),
      .mode_i(mode_i), .step_cnt_i(step_cnt_i), .limit_i(limit_i), .pc_i(pc_i),
      .bp_addr_i(bp_addr_i), .bp_en_i(bp_en_i), .run_en_o(run_en_o), .pc_clr_o(pc_clr_o),
      .state_o(state_o), .halt_cause_o(halt_cause_o), .retired_o(retired_o)
   );

   always #5 clk = ~clk;

   // Reference model: phase 0 idle, 1 running, 2 halted; m_left < 0 means no budget.
   int          m_phase;
   int          m_cause;
   logic [31:0] m_retired;
   int          m_left;
   int          m_kind;
   bit          m_first;
   bit          m_pclr;
   bit          m_clr_prev;

   function automatic bit m_limit();
      return (pc_i >> 2) == (limit_i & 32'h3FFF_FFFF);
   endfunction

   function automatic bit m_bp();
      bit hit = 1'b0;
`ifdef PC_RUN_CTRL_BP_EN
      for (int k = 0; k < NUM_BP; k++)
         if (bp_en_i[k] && bp_addr_i[k*PC_W +: PC_W] == pc_i) hit = 1'b1;
`endif
      return hit && !m_first;
   endfunction

   function automatic bit m_en();
      return m_phase == 1 && !m_limit() && !m_bp() && !stop_i && !clr_i;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0; m_cause = 0; m_retired = 0; m_left = 0; m_kind = 0;
         m_first = 1; m_pclr = 0; m_clr_prev = 0;
      end else begin
         bit en;
         en = m_en();
         if (en && m_retired != 32'hFFFF_FFFF) m_retired = m_retired + 1;
         m_pclr = clr_i && !m_clr_prev;
         m_clr_prev = clr_i;
         if (clr_i) begin
            m_phase = 0; m_cause = 0; m_retired = 0; m_left = 0; m_first = 1;
         end else if (stop_i) begin
            if (m_phase != 2) begin m_phase = 2; m_cause = 5; end
         end else if (start_i && m_phase != 1) begin
            m_cause = 0;
            m_first = 1;
            if (mode_i == 2'b10) begin
               m_left = int'(step_cnt_i); m_kind = 4;
               if (m_left == 0) begin m_phase = 2; m_cause = 4; end
               else m_phase = 1;
            end else if (mode_i == 2'b01) begin
               m_left = 1; m_kind = 3; m_phase = 1;
            end else begin
               m_left = -1; m_phase = 1;
            end
         end else if (m_phase == 1) begin
            bit bp_now;
            bp_now = m_bp();
            m_first = 0;
            if (m_limit()) begin m_phase = 2; m_cause = 1; end
            else if (bp_now) begin m_phase = 2; m_cause = 2; end
            else if (en && m_left > 0) begin
               m_left = m_left - 1;
               if (m_left == 0) begin m_phase = 2; m_cause = m_kind; end
            end
         end
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_on && !rst) begin
         cmp("run_en", 32'(run_en_o), 32'(m_en()));
         cmp("state", 32'(state_o), 32'(m_phase));
         cmp("cause", 32'(halt_cause_o), 32'(m_cause));
         cmp("retired", retired_o, m_retired);
         cmp("pc_clr", 32'(pc_clr_o), 32'(m_pclr));
      end
   end

   // One clock: the bench CPU advances pc_i by 4 whenever run_en_o was high at the edge.
   task automatic tick();
      logic en;
      @(negedge clk);
      en = run_en_o;
      @(posedge clk);
      #1;
      if (en) pc_i = pc_i + 32'd4;
      start_i = 1'b0;
      stop_i  = 1'b0;
      clr_i   = 1'b0;
   endtask

   task automatic run_until_halt(input int budget);
      int n = 0;
      while (state_o != 2'b10 && n < budget) begin
         tick();
         n++;
      end
      cmp("halt_reached", 32'(state_o), 32'd2);
   endtask

   task automatic clear_all();
      clr_i = 1'b1;
      tick();
      tick();
      pc_i = '0;
   endtask

   initial begin
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      mon_on = 1'b1;
      tick();
      cmp("rst_state", 32'(state_o), 32'd0);
      cmp("rst_cause", 32'(halt_cause_o), 32'd0);
      cmp("rst_retired", retired_o, 32'd0);
      cmp("rst_run_en", 32'(run_en_o), 32'd0);

      // Free run to the limit index 18.
      limit_i = 32'd18; mode_i = 2'b00; start_i = 1'b1;
      tick();
      run_until_halt(60);
      cmp("lim_cause", 32'(halt_cause_o), 32'd1);
      cmp("lim_retired", retired_o, 32'd18);
      cmp("lim_pc", pc_i, 32'h48);

      // Clear pulse.
      clr_i = 1'b1;
      tick();
      cmp("clr_pulse", 32'(pc_clr_o), 32'd1);
      cmp("clr_state", 32'(state_o), 32'd0);
      cmp("clr_retired", retired_o, 32'd0);
      tick();
      cmp("clr_pulse_end", 32'(pc_clr_o), 32'd0);
      pc_i = '0;

      // Breakpoint at 0x20 in slot 1, limit at 0x30.
      limit_i = 32'd12; bp_addr_i[1*PC_W +: PC_W] = 32'h20; bp_en_i = 4'b0010;
      start_i = 1'b1;
      tick();
      run_until_halt(60);
`ifdef PC_RUN_CTRL_BP_EN
      cmp("bp_cause", 32'(halt_cause_o), 32'd2);
      cmp("bp_pc", pc_i, 32'h20);
      cmp("bp_retired", retired_o, 32'd8);
      start_i = 1'b1;
      tick();
      run_until_halt(60);
`endif
      cmp("bp_end_cause", 32'(halt_cause_o), 32'd1);
      cmp("bp_end_pc", pc_i, 32'h30);
      cmp("bp_end_retired", retired_o, 32'd12);

      // Limit beats breakpoint on the same PC.
      bp_addr_i[0 +: PC_W] = 32'h10; bp_en_i = 4'b0001; limit_i = 32'd4; pc_i = 32'h8;
      start_i = 1'b1;
      tick();
      run_until_halt(20);
      cmp("prio_cause", 32'(halt_cause_o), 32'd1);
      cmp("prio_pc", pc_i, 32'h10);
      bp_en_i = '0;

      // Counted mode: 5, then 0.
      clear_all();
      limit_i = 32'd1000; mode_i = 2'b10; step_cnt_i = 16'd5; start_i = 1'b1;
      tick();
      run_until_halt(30);
      cmp("cnt5_cause", 32'(halt_cause_o), 32'd4);
      cmp("cnt5_retired", retired_o, 32'd5);
      cmp("cnt5_pc", pc_i, 32'h14);
      step_cnt_i = 16'd0; start_i = 1'b1;
      tick();
      cmp("cnt0_state", 32'(state_o), 32'd2);
      cmp("cnt0_cause", 32'(halt_cause_o), 32'd4);
      tick();
      cmp("cnt0_retired", retired_o, 32'd5);

      // Single-step three times.
      clear_all();
      mode_i = 2'b01;
      for (int i = 0; i < 3; i++) begin
         start_i = 1'b1;
         tick();
         run_until_halt(10);
         cmp("step_cause", 32'(halt_cause_o), 32'd3);
      end
      cmp("step_pc", pc_i, 32'hC);
      cmp("step_retired", retired_o, 32'd3);

      // Limit lowered during RUN takes effect at once.
      mode_i = 2'b00; limit_i = 32'd1000; start_i = 1'b1;
      tick(); tick(); tick();
      limit_i = pc_i >> 2;
      tick();
      cmp("dyn_cause", 32'(halt_cause_o), 32'd1);
      cmp("dyn_pc", pc_i, 32'h14);

      // start + stop + clr together, then stop + start in IDLE.
      start_i = 1'b1; stop_i = 1'b1; clr_i = 1'b1;
      tick();
      cmp("all3_pulse", 32'(pc_clr_o), 32'd1);
      cmp("all3_state", 32'(state_o), 32'd0);
      cmp("all3_cause", 32'(halt_cause_o), 32'd0);
      cmp("all3_retired", retired_o, 32'd0);
      start_i = 1'b1; stop_i = 1'b1;
      tick();
      cmp("stop_state", 32'(state_o), 32'd2);
      cmp("stop_cause", 32'(halt_cause_o), 32'd5);

      // Asynchronous reset between edges while running.
      pc_i = '0; limit_i = 32'd1000; start_i = 1'b1;
      tick(); tick(); tick();
      cmp("pre_rst_run_en", 32'(run_en_o), 32'd1);
      #2 rst = 1'b1;
      #1;
      cmp("async_run_en", 32'(run_en_o), 32'd0);
      cmp("async_state", 32'(state_o), 32'd0);
      cmp("async_retired", retired_o, 32'd0);
      cmp("async_cause", 32'(halt_cause_o), 32'd0);
      cmp("async_pc_clr", 32'(pc_clr_o), 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      tick();
      cmp("post_rst_state", 32'(state_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule
